barrel_shifter_pipe: RTL and testbench



---
 rtl/barrel_shifter_pkg.sv | 15 +
 rtl/barrel_shifter_pipe_if.sv | 30 +++
 rtl/barrel_shifter_pipe_shift_stage.sv | 62 ++++++
 rtl/barrel_shifter_pipe.sv | 58 +++++
 tb/tb_barrel_shifter_pipe.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared constants and helpers for the pipelined barrel shifter.
// Operation encodings match the in_mode field of the operand bus.
package barrel_shifter_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Shift-amount width for a power-of-two data width; never below one bit.
    function automatic int shamt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand and result handshake bus of the barrel shifter.
// The shifter takes the slave side; the producer/consumer takes master.
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 8
);
    import barrel_shifter_pkg::*;

    localparam int SHW = shamt_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );

endinterface

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// One pipeline stage: shifts the upstream operand by STEP when its shamt
// bit is set, then registers the result together with the handshake state.
module shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SHW-1:0]   up_shamt,
    input  logic [1:0]       up_mode,
    input  logic             dn_ready,
    output logic             stage_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shamt,
    output logic [1:0]       mode
);

    localparam int BIT = $clog2(STEP);

    logic [WIDTH-1:0] shifted;

    // For SRA the operand MSB is still the original sign, since every earlier
    // arithmetic stage refilled it with that same bit.
    always_comb begin
        // NOTE: default assigned first so no path leaves shifted unassigned (no latch).
        shifted = up_data;
        if (up_shamt[BIT]) begin
            case (up_mode)
                MODE_SLL: shifted = up_data << STEP;
                MODE_SRL: shifted = up_data >> STEP;
                MODE_SRA: shifted = $signed(up_data) >>> STEP;
                default:  shifted = (up_data >> STEP) | (up_data << (WIDTH - STEP));
            endcase
        end
    end

    // An empty stage, or one whose contents leave this cycle, can take new data.
    assign stage_ready = !valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data is reset as well as valid so out_data reads zero after reset.
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            mode  <= MODE_SLL;
        end else if (stage_ready) begin
            // NOTE: non-blocking so every stage samples its upstream pre-edge value.
            valid <= up_valid;
            data  <= shifted;
            shamt <= up_shamt;
            mode  <= up_mode;
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one stage per shift-amount bit,
// full-throughput valid/ready handshake on both sides.
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    barrel_shifter_pipe_if.slave bus
);

    localparam int SHW = shamt_width(WIDTH);

    // Index 0 is the operand bus; index k+1 is the register output of stage k.
    logic             valid_c [SHW+1];
    logic             ready_c [SHW+1];
    logic [WIDTH-1:0] data_c  [SHW+1];
    logic [SHW-1:0]   shamt_c [SHW+1];
    logic [1:0]       mode_c  [SHW+1];

    assign valid_c[0]   = bus.in_valid;
    assign data_c[0]    = bus.in_data;
    assign shamt_c[0]   = bus.in_shamt;
    assign mode_c[0]    = bus.in_mode;
    assign ready_c[SHW] = bus.out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .STEP  (1 << k)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .up_valid    (valid_c[k]),
            .up_data     (data_c[k]),
            .up_shamt    (shamt_c[k]),
            .up_mode     (mode_c[k]),
            .dn_ready    (ready_c[k+1]),
            .stage_ready (ready_c[k]),
            .valid       (valid_c[k+1]),
            .data        (data_c[k+1]),
            .shamt       (shamt_c[k+1]),
            .mode        (mode_c[k+1])
        );
    end

    // The last stage's shamt/mode have no consumer beyond the pipe.
    logic unused_tail;
    assign unused_tail = ^{shamt_c[SHW], mode_c[SHW]};

    assign bus.in_ready  = ready_c[0];
    assign bus.out_valid = valid_c[SHW];
    assign bus.out_data  = data_c[SHW];
    assign bus.out_zero  = valid_c[SHW] && (data_c[SHW] == '0);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench: directed cases at WIDTH=8, then randomized streams at
// WIDTH=8 and WIDTH=32 against a whole-shift arithmetic reference model.
module tb_barrel_shifter_pipe;
    import barrel_shifter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    barrel_shifter_pipe_if #(.WIDTH(8))  b8  ();
    barrel_shifter_pipe_if #(.WIDTH(32)) b32 ();

    barrel_shifter_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    barrel_shifter_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));

    int vectors = 0;
    int miscompares = 0;

    longint unsigned q8[$];
    longint unsigned q32[$];

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole shift in one step, straight from the operation definitions.
    function automatic longint unsigned ref_shift(input longint unsigned d, input int s,
                                                  input logic [1:0] m, input int w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned r;
        d = d & mask;
        case (m)
            MODE_SLL: r = d << s;
            MODE_SRL: r = d >> s;
            MODE_SRA: begin
                r = d >> s;
                if (((d >> (w - 1)) & 64'd1) != 0) r = r | (mask & ~(mask >> s));
            end
            default:  r = (s == 0) ? d : ((d >> s) | (d << (w - s)));
        endcase
        return r & mask;
    endfunction

    task automatic single8(input string tag, input logic [7:0] d, input int s,
                           input logic [1:0] m, input logic [7:0] exp);
        int cyc;
        @(negedge clk);
        b8.in_valid  = 1'b1;
        b8.in_data   = d;
        b8.in_shamt  = 3'(s);
        b8.in_mode   = m;
        b8.out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(b8.in_ready), 64'd1);
        @(negedge clk);
        b8.in_valid = 1'b0;
        cyc = 1;
        while (!b8.out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd3);
        check({tag, "_data"}, 64'(b8.out_data), 64'(exp));
        check({tag, "_zero"}, 64'(b8.out_zero), 64'(exp == 8'h00));
    endtask

    initial begin
        logic [7:0] bp_d [6];
        int         bp_s [6];
        logic [1:0] bp_m [6];
        int sent;
        int acc8, acc32;
        bit hold8, hold32;
        longint unsigned e;

        b8.in_valid = 0;  b8.in_data = '0;  b8.in_shamt = '0;  b8.in_mode = '0;  b8.out_ready = 0;
        b32.in_valid = 0; b32.in_data = '0; b32.in_shamt = '0; b32.in_mode = '0; b32.out_ready = 0;

        // Reset state.
        #12;
        check("rst_out_valid", 64'(b8.out_valid), 64'd0);
        check("rst_out_data",  64'(b8.out_data),  64'd0);
        check("rst_out_zero",  64'(b8.out_zero),  64'd0);
        check("rst_in_ready",  64'(b8.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single ops.
        single8("sll81_1", 8'h81, 1, MODE_SLL, 8'h02);
        single8("sll90_3", 8'h90, 3, MODE_SLL, 8'h80);
        single8("srl90_3", 8'h90, 3, MODE_SRL, 8'h12);
        single8("sra90_3", 8'h90, 3, MODE_SRA, 8'hF2);
        single8("ror90_3", 8'h90, 3, MODE_ROR, 8'h12);
        single8("ror81_1", 8'h81, 1, MODE_ROR, 8'hC0);
        single8("sra7f_7", 8'h7F, 7, MODE_SRA, 8'h00);
        for (int m = 0; m < 4; m++) single8($sformatf("zero_shift_m%0d", m), 8'hA5, 0, 2'(m), 8'hA5);

        // Back-pressure: six ops against a stalled consumer.
        for (int i = 0; i < 6; i++) begin
            bp_d[i] = 8'($urandom);
            bp_s[i] = int'($urandom_range(1, 7));
            bp_m[i] = 2'(i % 4);
        end
        @(negedge clk);
        b8.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            b8.in_valid = (sent < 6);
            if (sent < 6) begin
                b8.in_data = bp_d[sent]; b8.in_shamt = 3'(bp_s[sent]); b8.in_mode = bp_m[sent];
            end
            #1;
            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(ref_shift(64'(bp_d[sent]), bp_s[sent], bp_m[sent], 8));
                sent++;
            end
        end
        check("bp_accepts", 64'(sent), 64'd3);
        check("bp_in_ready_low", 64'(b8.in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 64'(b8.out_valid), 64'd1);
            check("bp_hold_data", 64'(b8.out_data), (q8.size() > 0) ? q8[0] : 64'hDEAD);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            b8.out_ready = 1'b1;
            b8.in_valid = (sent < 6);
            if (sent < 6) begin
                b8.in_data = bp_d[sent]; b8.in_shamt = 3'(bp_s[sent]); b8.in_mode = bp_m[sent];
            end
            #1;
            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(ref_shift(64'(bp_d[sent]), bp_s[sent], bp_m[sent], 8));
                sent++;
            end
            check("bp_out_valid", 64'(b8.out_valid), 64'd1);
            if (b8.out_valid && q8.size() > 0) check("bp_out_data", 64'(b8.out_data), q8.pop_front());
        end
        @(negedge clk);
        b8.in_valid = 1'b0;
        #1;
        check("bp_all_sent", 64'(sent), 64'd6);
        check("bp_drained", 64'(q8.size()), 64'd0);
        check("bp_no_dup", 64'(b8.out_valid), 64'd0);

        // Reset with three ops in flight.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            b8.in_valid = 1'b1; b8.in_data = 8'($urandom | 1); b8.in_shamt = 3'(c); b8.in_mode = MODE_ROR;
        end
        @(negedge clk);
        b8.in_valid = 1'b0;
        check("flight_out_valid", 64'(b8.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(b8.out_valid), 64'd0);
        check("midrst_out_data",  64'(b8.out_data),  64'd0);
        check("midrst_out_zero",  64'(b8.out_zero),  64'd0);
        check("midrst_in_ready",  64'(b8.in_ready),  64'd1);
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 check("midrst_no_stale", 64'(b8.out_valid), 64'd0);
        end

        // Randomized streams on both widths.
        acc8 = 0; acc32 = 0; hold8 = 0; hold32 = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (acc8 >= 1000 && acc32 >= 1000 && q8.size() == 0 && q32.size() == 0) break;
            @(negedge clk);
            if (!hold8) begin
                b8.in_valid = (acc8 < 1000) && ($urandom_range(0, 3) != 0);
                b8.in_data  = 8'($urandom);
                b8.in_shamt = 3'($urandom);
                b8.in_mode  = 2'($urandom);
            end
            b8.out_ready = ($urandom_range(0, 3) != 0);
            if (!hold32) begin
                b32.in_valid = (acc32 < 1000) && ($urandom_range(0, 3) != 0);
                b32.in_data  = 32'($urandom);
                b32.in_shamt = 5'($urandom);
                b32.in_mode  = 2'($urandom);
            end
            b32.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) check("r8_unexpected", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front();
                    check("r8_data", 64'(b8.out_data), e);
                    check("r8_zero", 64'(b8.out_zero), 64'(e == 0));
                end
            end
            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(ref_shift(64'(b8.in_data), int'(b8.in_shamt), b8.in_mode, 8));
                acc8++;
                hold8 = 0;
            end else hold8 = b8.in_valid;
            if (b32.out_valid && b32.out_ready) begin
                if (q32.size() == 0) check("r32_unexpected", 64'd1, 64'd0);
                else begin
                    e = q32.pop_front();
                    check("r32_data", 64'(b32.out_data), e);
                    check("r32_zero", 64'(b32.out_zero), 64'(e == 0));
                end
            end
            if (b32.in_valid && b32.in_ready) begin
                q32.push_back(ref_shift(64'(b32.in_data), int'(b32.in_shamt), b32.in_mode, 32));
                acc32++;
                hold32 = 0;
            end else hold32 = b32.in_valid;
        end
        check("r8_accepted",  64'(acc8),  64'd1000);
        check("r32_accepted", 64'(acc32), 64'd1000);
        check("r8_drained",   64'(q8.size()),  64'd0);
        check("r32_drained",  64'(q32.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
